output_demux: RTL and testbench
===============================

Name: output_demux

Overview:
- Packet-stream demultiplexer; the fan-out counterpart of the input arbiter.
- Accepts the single merged stream leaving the pipeline and steers each packet to one or more of NUM_OUTPUT_QUEUES output queues.
- The destination is a one-hot/multi-hot mask carried in the packet's first module-header word.
- Packets with no valid destination are dropped. Forwarded and dropped packets are counted.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- NUM_OUTPUT_QUEUES, 8, number of output queues.
- IOQ_CTRL, 8'hFF, ctrl value identifying the destination header word.
- DST_POS, 16, LSB of the destination mask field inside the header data word.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  input word
- in_ctrl  in  CTRL_WIDTH  input ctrl
- in_wr  in  1  input write strobe
- in_rdy  out  1  input may write; equals !nearly_full of the internal fifo
- out_data  out  DATA_WIDTH  shared output data, registered
- out_ctrl  out  CTRL_WIDTH  shared output ctrl, registered
- out_wr  out  NUM_OUTPUT_QUEUES  per-queue write strobe, registered
- out_rdy  in  NUM_OUTPUT_QUEUES  per-queue ready
- pkts_fwd  out  32  packets forwarded (EOP written), wrapping
- pkts_drop  out  32  packets dropped, wrapping

Behaviour:
- Input buffering
  - Internal fifo, 4 deep, width CTRL_WIDTH+DATA_WIDTH.
  - nearly_full asserts at 3 entries; in_rdy = !nearly_full.
  - A word is written whenever in_wr=1. The upstream block must honour in_rdy.
  - The head word is visible while !empty; rd_en pops it.
- Packet framing
  - The first word of a packet is a header with in_ctrl != 0.
  - Subsequent module headers have ctrl != 0; data words have ctrl == 0.
  - EOP = a word with ctrl != 0 while prev_ctrl == 0.
  - prev_ctrl is the ctrl of the last word consumed. It is set to 1 on reset and when a packet starts.
- States: IDLE, WR_PKT, DROP_PKT.
- IDLE, head word present:
  - If head ctrl == IOQ_CTRL and mask = data[DST_POS+N-1:DST_POS] != 0, then latch dst_mask = mask.
    - If (out_rdy & mask) == mask: pop, out_wr_next = mask, go to WR_PKT.
    - Otherwise stall in IDLE with the mask held, no pop.
  - Otherwise (wrong ctrl or zero mask): pop, no write, go to DROP_PKT.
- WR_PKT:
  - Pop and write (out_wr_next = dst_mask) only when !empty and (out_rdy & dst_mask) == dst_mask. Multicast words advance in lockstep to all masked queues.
  - The EOP word is written, pkts_fwd increments, and the block returns to IDLE.
  - Otherwise stall with out_wr = 0.
- DROP_PKT:
  - Pop every cycle while !empty, ignoring out_rdy, with no writes.
  - On EOP, pkts_drop increments and the block returns to IDLE.
- Outputs
  - out_data/out_ctrl are the registered head word, updated every cycle. They are meaningful only when out_wr != 0.
  - Latency is 1 cycle from the pop decision to out_wr.
  - Unmasked bits of out_wr are always 0.
- Reset values:
  - state = IDLE, dst_mask = 0, prev_ctrl = 1.
  - out_wr = 0, out_ctrl = 0, out_data = 0.
  - pkts_fwd = pkts_drop = 0, fifo empty (in_rdy = 1).
  - Reset mid-packet discards the buffered words and the partial packet. Downstream may hold a truncated packet; that is accepted.
- Simultaneous events:
  - A fifo write and pop in the same cycle is legal; occupancy is unchanged.
  - A counter wrapping at 2^32-1 goes to 0.
  - out_rdy deasserting on any masked queue stalls the whole packet. No partial-multicast advance is allowed.

Test Plan:
- Unicast: header ctrl=FF, data[23:16]=8'h04, 2 data words, EOP ctrl=0x01.
  - Required: out_wr=8'h04 for 4 consecutive cycles, words in order, pkts_fwd=1.
- Multicast with backpressure: mask 8'h81; out_rdy[7] low for 5 cycles mid-packet.
  - Required: no out_wr during the stall.
  - Required: all words delivered with out_wr=8'h81 and none duplicated.
- Drop, two cases:
  - Case A: mask 0. Case B: first word ctrl=0x02.
  - Required in both: all packet words consumed with out_wr=0, pkts_drop=1, and the next valid packet forwarded normally.
- Fifo full: hold out_rdy=0 and stream words.
  - Required: in_rdy drops after 3 entries.
  - Required: after out_rdy=1, no word is lost or reordered.
- Reset mid-packet: assert reset after 2 words of a 6-word packet.
  - Required: out_wr=0, counters=0, in_rdy=1.
  - Required: a following packet forwards correctly.
- Back-to-back packets: EOP of packet A immediately followed by the header of packet B to a different mask.
  - Required: B starts within 1 cycle after A's EOP write, and pkts_fwd=2.

Source files
------------

// File: rtl/output_demux.sv
// output_demux: steers packets from one merged stream to NUM_OUTPUT_QUEUES output queues.
// The destination mask is read from the header word whose ctrl equals IOQ_CTRL.
// Packets with no valid destination are dropped. Forwarded and dropped packets are counted.
// Latency: 1 cycle from the fifo pop decision to out_wr/out_data/out_ctrl.
// Backpressure: a packet advances only when every masked queue is ready, so it stalls as a whole.
//   Upstream is throttled by in_rdy, which is !nearly_full of the 4-deep input fifo.
// Ports: clk/reset (synchronous, active-high); in_data/in_ctrl/in_wr/in_rdy form the input stream;
//   out_data/out_ctrl are shared by all queues, out_wr is the per-queue strobe, out_rdy the per-queue ready;
//   pkts_fwd/pkts_drop are wrapping packet counters.

module output_demux_fifo #(
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);
  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             do_wr;
  logic             do_rd;

  assign empty       = (count == 3'd0);
  assign nearly_full = (count >= 3'd3);
  assign dout        = mem[rd_ptr];
  assign do_rd       = rd_en && !empty;
  // A write into a full fifo is only safe when the head leaves in the same cycle.
  assign do_wr       = wr_en && ((count != 3'd4) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 2'd1;
      if (do_rd) rd_ptr <= rd_ptr + 2'd1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

module output_demux #(
  parameter int                    DATA_WIDTH        = 64,
  parameter int                    CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int                    NUM_OUTPUT_QUEUES = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL          = 8'hFF,
  parameter int                    DST_POS           = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
  output logic [31:0]                  pkts_fwd,
  output logic [31:0]                  pkts_drop
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_PKT   = 2'd1,
    DROP_PKT = 2'd2
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [NUM_OUTPUT_QUEUES-1:0]   dst_mask;
  logic [NUM_OUTPUT_QUEUES-1:0]   dst_mask_next;
  logic [CTRL_WIDTH-1:0]          prev_ctrl;
  logic [CTRL_WIDTH-1:0]          prev_ctrl_next;
  logic [NUM_OUTPUT_QUEUES-1:0]   out_wr_next;
  logic                           rd_en;
  logic                           fwd_inc;
  logic                           drop_inc;

  logic                           empty;
  logic                           nearly_full;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] head;
  logic [CTRL_WIDTH-1:0]          head_ctrl;
  logic [DATA_WIDTH-1:0]          head_data;
  logic [NUM_OUTPUT_QUEUES-1:0]   head_mask;
  logic                           eop;

  output_demux_fifo #(
    .WIDTH(CTRL_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (in_wr),
    .din        ({in_ctrl, in_data}),
    .rd_en      (rd_en),
    .dout       (head),
    .empty      (empty),
    .nearly_full(nearly_full)
  );

  assign in_rdy    = !nearly_full;
  assign head_ctrl = head[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];
  assign head_mask = head_data[DST_POS +: NUM_OUTPUT_QUEUES];
  // EOP is the first non-zero ctrl following a data word (ctrl == 0).
  assign eop       = (head_ctrl != '0) && (prev_ctrl == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dst_mask  <= '0;
      prev_ctrl <= CTRL_WIDTH'(1);
      out_wr    <= '0;
      out_data  <= '0;
      out_ctrl  <= '0;
      pkts_fwd  <= '0;
      pkts_drop <= '0;
    end else begin
      state     <= state_next;
      dst_mask  <= dst_mask_next;
      prev_ctrl <= prev_ctrl_next;
      out_wr    <= out_wr_next;
      out_data  <= head_data;
      out_ctrl  <= head_ctrl;
      if (fwd_inc)  pkts_fwd  <= pkts_fwd + 32'd1;
      if (drop_inc) pkts_drop <= pkts_drop + 32'd1;
    end
  end

  always_comb begin
    state_next     = state;
    dst_mask_next  = dst_mask;
    prev_ctrl_next = prev_ctrl;
    out_wr_next    = '0;
    rd_en          = 1'b0;
    fwd_inc        = 1'b0;
    drop_inc       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if ((head_ctrl == IOQ_CTRL) && (head_mask != '0)) begin
            dst_mask_next = head_mask;
            // Header waits in the fifo until every destination can take it.
            if ((out_rdy & head_mask) == head_mask) begin
              rd_en          = 1'b1;
              out_wr_next    = head_mask;
              prev_ctrl_next = CTRL_WIDTH'(1);
              state_next     = WR_PKT;
            end
          end else begin
            rd_en          = 1'b1;
            prev_ctrl_next = CTRL_WIDTH'(1);
            state_next     = DROP_PKT;
          end
        end
      end
      WR_PKT: begin
        // All masked queues advance together; any one not ready holds the whole packet.
        if (!empty && ((out_rdy & dst_mask) == dst_mask)) begin
          rd_en          = 1'b1;
          out_wr_next    = dst_mask;
          prev_ctrl_next = head_ctrl;
          if (eop) begin
            fwd_inc    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DROP_PKT: begin
        if (!empty) begin
          rd_en          = 1'b1;
          prev_ctrl_next = head_ctrl;
          if (eop) begin
            drop_inc   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_output_demux.sv
// Testbench for output_demux: scoreboard of expected output words, per-scenario tasks.
module tb_output_demux;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NQ = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NQ-1:0] out_wr;
  logic [NQ-1:0] out_rdy;
  logic [31:0]   pkts_fwd;
  logic [31:0]   pkts_drop;

  typedef struct packed {
    logic [NQ-1:0] mask;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    fails = 0;
  int    exp_fwd = 0;
  int    exp_drop = 0;

  output_demux dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_wr    (in_wr),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy),
    .pkts_fwd (pkts_fwd),
    .pkts_drop(pkts_drop)
  );

  always #5 clk = ~clk;

  // Every output write must match the oldest expected word.
  task automatic monitor_out();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_wr !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got out_wr=%h ctrl=%h data=%h required no write", out_wr, out_ctrl, out_data);
        end else begin
          e = sb.pop_front();
          if (out_wr !== e.mask || out_ctrl !== e.ctrl || out_data !== e.data) begin
            fails++;
            $display("FAIL out_word: got wr=%h ctrl=%h data=%h required wr=%h ctrl=%h data=%h",
                     out_wr, out_ctrl, out_data, e.mask, e.ctrl, e.data);
          end
        end
      end
    end
  endtask

  task automatic send_word(input logic [CW-1:0] c, input logic [DW-1:0] d);
    int t = 0;
    while (!in_rdy && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 500) begin
      fails++;
      $display("FAIL in_rdy_timeout: got in_rdy=%b required 1 within 500 cycles", in_rdy);
    end
    in_ctrl = c;
    in_data = d;
    in_wr   = 1'b1;
    @(negedge clk);
    in_wr   = 1'b0;
  endtask

  // Header ctrl hctrl with mask in data[23:16], data words with ctrl 0, EOP ctrl 0x01.
  task automatic send_pkt(input logic [CW-1:0] hctrl, input logic [NQ-1:0] mask, input int nwords,
                          input bit fwd, input logic [NQ-1:0] exp_mask);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    exp_t e;
    for (int i = 0; i < nwords; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) begin
        c = hctrl;
        d[23:16] = mask;
      end else if (i == nwords - 1) begin
        c = 8'h01;
      end else begin
        c = 8'h00;
      end
      if (fwd) begin
        e.mask = exp_mask;
        e.ctrl = c;
        e.data = d;
        sb.push_back(e);
      end
      send_word(c, d);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d words outstanding required 0", sb.size());
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    in_wr = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_fwd  = 0;
    exp_drop = 0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    in_wr   = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    out_rdy = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (out_wr !== 8'h00) begin fails++; $display("FAIL reset_out_wr: got %h required 00", out_wr); end
    checks++; if (out_ctrl !== 8'h00) begin fails++; $display("FAIL reset_out_ctrl: got %h required 00", out_ctrl); end
    checks++; if (out_data !== 64'h0) begin fails++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    checks++; if (pkts_fwd !== 32'd0 || pkts_drop !== 32'd0) begin
      fails++; $display("FAIL reset_counters: got fwd=%0d drop=%0d required 0 0", pkts_fwd, pkts_drop);
    end
    checks++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy: got %b required 1", in_rdy); end
  endtask

  task automatic test_unicast();
    fork
      send_pkt(8'hFF, 8'h04, 4, 1'b1, 8'h04);
      begin
        int t = 0;
        while (out_wr === '0 && t < 100) begin
          @(negedge clk);
          t++;
        end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (out_wr !== 8'h04) begin
            fails++; $display("FAIL unicast_consecutive[%0d]: got out_wr=%h required 04", k, out_wr);
          end
          if (k < 3) @(negedge clk);
        end
      end
    join
    exp_fwd++;
    drain();
    checks++; if (pkts_fwd !== 32'(exp_fwd)) begin fails++; $display("FAIL unicast_fwd: got %0d required %0d", pkts_fwd, exp_fwd); end
  endtask

  task automatic test_multicast_bp();
    fork
      send_pkt(8'hFF, 8'h81, 8, 1'b1, 8'h81);
      begin
        repeat (3) @(negedge clk);
        out_rdy[7] = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (out_wr !== 8'h00) begin
            fails++; $display("FAIL mcast_stall[%0d]: got out_wr=%h required 00", k, out_wr);
          end
        end
        out_rdy[7] = 1'b1;
      end
    join
    exp_fwd++;
    drain();
    checks++; if (pkts_fwd !== 32'(exp_fwd)) begin fails++; $display("FAIL mcast_fwd: got %0d required %0d", pkts_fwd, exp_fwd); end
  endtask

  task automatic test_drop();
    // Case A: zero mask.
    send_pkt(8'hFF, 8'h00, 4, 1'b0, 8'h00);
    exp_drop++;
    send_pkt(8'hFF, 8'h20, 3, 1'b1, 8'h20);
    exp_fwd++;
    drain();
    checks++; if (pkts_drop !== 32'(exp_drop)) begin fails++; $display("FAIL dropA_count: got %0d required %0d", pkts_drop, exp_drop); end
    checks++; if (pkts_fwd !== 32'(exp_fwd)) begin fails++; $display("FAIL dropA_fwd: got %0d required %0d", pkts_fwd, exp_fwd); end
    // Case B: first word carries a non-destination ctrl.
    send_pkt(8'h02, 8'h40, 5, 1'b0, 8'h00);
    exp_drop++;
    send_pkt(8'hFF, 8'h40, 4, 1'b1, 8'h40);
    exp_fwd++;
    drain();
    checks++; if (pkts_drop !== 32'(exp_drop)) begin fails++; $display("FAIL dropB_count: got %0d required %0d", pkts_drop, exp_drop); end
    checks++; if (pkts_fwd !== 32'(exp_fwd)) begin fails++; $display("FAIL dropB_fwd: got %0d required %0d", pkts_fwd, exp_fwd); end
  endtask

  task automatic test_fifo_full();
    logic [CW-1:0] c[6];
    logic [DW-1:0] d[6];
    exp_t e;
    out_rdy = '0;
    for (int i = 0; i < 6; i++) begin
      d[i] = {$urandom, $urandom};
      c[i] = (i == 0) ? 8'hFF : ((i == 5) ? 8'h01 : 8'h00);
      if (i == 0) d[i][23:16] = 8'h08;
      e.mask = 8'h08;
      e.ctrl = c[i];
      e.data = d[i];
      sb.push_back(e);
    end
    send_word(c[0], d[0]);
    send_word(c[1], d[1]);
    checks++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL full_two_entries: got in_rdy=%b required 1", in_rdy); end
    send_word(c[2], d[2]);
    checks++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL full_three_entries: got in_rdy=%b required 0", in_rdy); end
    fork
      begin
        for (int i = 3; i < 6; i++) send_word(c[i], d[i]);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checks++;
          if (out_wr !== 8'h00 || in_rdy !== 1'b0) begin
            fails++; $display("FAIL full_hold[%0d]: got out_wr=%h in_rdy=%b required 00 0", k, out_wr, in_rdy);
          end
        end
        out_rdy = '1;
      end
    join
    exp_fwd++;
    drain();
    checks++; if (pkts_fwd !== 32'(exp_fwd)) begin fails++; $display("FAIL full_fwd: got %0d required %0d", pkts_fwd, exp_fwd); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[23:16] = 8'h04;
    // Only the header leaves before reset lands; the second word is still buffered.
    e.mask = 8'h04; e.ctrl = 8'hFF; e.data = d;
    sb.push_back(e);
    send_word(8'hFF, d);
    send_word(8'h00, {$urandom, $urandom});
    do_reset();
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL rstmid_truncated: got %0d headers unwritten required 0", sb.size()); end
    checks++; if (out_wr !== 8'h00) begin fails++; $display("FAIL rstmid_out_wr: got %h required 00", out_wr); end
    checks++; if (pkts_fwd !== 32'd0 || pkts_drop !== 32'd0) begin
      fails++; $display("FAIL rstmid_counters: got fwd=%0d drop=%0d required 0 0", pkts_fwd, pkts_drop);
    end
    checks++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL rstmid_in_rdy: got %b required 1", in_rdy); end
    repeat (4) @(negedge clk);
    checks++; if (out_wr !== 8'h00) begin fails++; $display("FAIL rstmid_no_leftover: got out_wr=%h required 00", out_wr); end
    send_pkt(8'hFF, 8'h10, 5, 1'b1, 8'h10);
    exp_fwd++;
    drain();
    checks++; if (pkts_fwd !== 32'(exp_fwd)) begin fails++; $display("FAIL rstmid_fwd: got %0d required %0d", pkts_fwd, exp_fwd); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      begin
        send_pkt(8'hFF, 8'h02, 4, 1'b1, 8'h02);
        send_pkt(8'hFF, 8'h10, 3, 1'b1, 8'h10);
      end
      begin
        int t = 0;
        while (!(out_wr === 8'h02 && out_ctrl === 8'h01) && t < 200) begin
          @(negedge clk);
          t++;
        end
        checks++;
        if (t >= 200) begin
          fails++; $display("FAIL b2b_eop_timeout: got no EOP write of A required one within 200 cycles");
        end else begin
          @(negedge clk);
          if (out_wr !== 8'h10 || out_ctrl !== 8'hFF) begin
            fails++; $display("FAIL b2b_next_header: got wr=%h ctrl=%h required wr=10 ctrl=ff", out_wr, out_ctrl);
          end
        end
      end
    join
    exp_fwd += 2;
    drain();
    checks++; if (pkts_fwd !== 32'd2) begin fails++; $display("FAIL b2b_fwd: got %0d required 2", pkts_fwd); end
  endtask

  initial begin
    test_reset();
    fork
      monitor_out();
    join_none
    test_unicast();
    test_multicast_bp();
    test_drop();
    test_fifo_full();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
